// File: rtl/pipe_pkg.sv
// Shared EX-stage pipeline types: forward-select encodings and the
// pipeline-register tuple carried through EX/MEM.
package pipe_pkg;

  localparam int XLEN   = 64;
  localparam int RIDX_W = 5;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b01
  } fwd_sel_e;

  typedef struct packed {
    logic [RIDX_W-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic [XLEN-1:0]   result;
  } pipe_reg_t;

endpackage

// File: rtl/ex_forward_hazard_unit_fwd_select.sv
// Per-operand forward select: youngest in-flight producer wins, x0 never forwarded.
module fwd_select
  import pipe_pkg::*;
(
  input  logic [RIDX_W-1:0] i_rs,
  input  logic [RIDX_W-1:0] i_em_rd,
  input  logic              i_em_reg_write,
  input  logic              i_em_mem_read,
  input  logic [RIDX_W-1:0] i_wb_rd,
  input  logic              i_wb_reg_write,
  output fwd_sel_e          o_sel
);

  logic w_em_hit;
  logic w_wb_hit;

  // A load sitting in EX/MEM has no data yet; the load-use stall keeps it from matching.
  assign w_em_hit = i_em_reg_write && !i_em_mem_read && (i_em_rd != '0) && (i_em_rd == i_rs);
  assign w_wb_hit = i_wb_reg_write && (i_wb_rd != '0) && (i_wb_rd == i_rs);

  always_comb begin
    o_sel = FWD_REG;
    if (w_em_hit) begin
      o_sel = FWD_MEM;
    end else if (w_wb_hit) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/ex_forward_hazard_unit.sv
// EX-stage producer side: EX/MEM and MEM/WB registers, operand forwarding,
// load-use stall request and a saturating stall counter.
module ex_forward_hazard_unit #(
  parameter int XLEN   = pipe_pkg::XLEN,
  parameter int RIDX_W = pipe_pkg::RIDX_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ex_valid,
  input  logic [RIDX_W-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [XLEN-1:0]   ex_result,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic [RIDX_W-1:0] idex_rs1,
  input  logic [RIDX_W-1:0] idex_rs2,
  input  logic [RIDX_W-1:0] ifid_rs1,
  input  logic [RIDX_W-1:0] ifid_rs2,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic [XLEN-1:0]   em_result,
  output logic [XLEN-1:0]   wb_result,
  output logic [RIDX_W-1:0] wb_rd,
  output logic              wb_reg_write,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  import pipe_pkg::*;

  pipe_reg_t         r_em;
  logic [RIDX_W-1:0] r_wb_rd;
  logic              r_wb_reg_write;
  logic [XLEN-1:0]   r_wb_result;
  logic [CNT_W-1:0]  r_stall_count;

  logic              w_stall;
  fwd_sel_e          w_fwd_a;
  fwd_sel_e          w_fwd_b;

  assign w_stall = ex_valid && ex_mem_read && (ex_rd != '0) &&
                   ((ex_rd == ifid_rs1) || (ex_rd == ifid_rs2));

  // No enable: a stall reaches these registers only as the ex_valid=0 bubble.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_em           <= '0;
      r_wb_rd        <= '0;
      r_wb_reg_write <= 1'b0;
      r_wb_result    <= '0;
      r_stall_count  <= '0;
    end else begin
      r_em.rd        <= ex_rd;
      r_em.reg_write <= ex_reg_write && ex_valid;
      r_em.mem_read  <= ex_mem_read && ex_valid;
      r_em.result    <= ex_result;
      r_wb_rd        <= r_em.rd;
      r_wb_reg_write <= r_em.reg_write;
      r_wb_result    <= r_em.mem_read ? mem_rdata : r_em.result;
      if (w_stall && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end
  end

  fwd_select u_fwd_a (
    .i_rs           (idex_rs1),
    .i_em_rd        (r_em.rd),
    .i_em_reg_write (r_em.reg_write),
    .i_em_mem_read  (r_em.mem_read),
    .i_wb_rd        (r_wb_rd),
    .i_wb_reg_write (r_wb_reg_write),
    .o_sel          (w_fwd_a)
  );

  fwd_select u_fwd_b (
    .i_rs           (idex_rs2),
    .i_em_rd        (r_em.rd),
    .i_em_reg_write (r_em.reg_write),
    .i_em_mem_read  (r_em.mem_read),
    .i_wb_rd        (r_wb_rd),
    .i_wb_reg_write (r_wb_reg_write),
    .o_sel          (w_fwd_b)
  );

  assign forward_a    = w_fwd_a;
  assign forward_b    = w_fwd_b;
  assign em_result    = r_em.result;
  assign wb_result    = r_wb_result;
  assign wb_rd        = r_wb_rd;
  assign wb_reg_write = r_wb_reg_write;
  assign stall        = w_stall;
  assign stall_count  = r_stall_count;

endmodule

// File: tb/tb_ex_forward_hazard_unit.sv
// Scoreboard bench: stimulus pushes expected outputs from a producer-history
// model; a negedge monitor pops and compares against two DUT builds.
module tb_ex_forward_hazard_unit;

  logic        clk = 1'b1;
  logic        reset_n;
  logic        ex_valid, ex_reg_write, ex_mem_read;
  logic [4:0]  ex_rd, idex_rs1, idex_rs2, ifid_rs1, ifid_rs2;
  logic [63:0] ex_result, mem_rdata;

  logic [1:0]  forward_a, forward_b, fa4, fb4;
  logic [63:0] em_result, wb_result, em4, wb4;
  logic [4:0]  wb_rd, wbrd4;
  logic        wb_reg_write, stall, wbwe4, stall4;
  logic [31:0] stall_count;
  logic [3:0]  stall_count4;

  always #5 clk = ~clk;

  ex_forward_hazard_unit dut (
    .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_result(ex_result),
    .mem_rdata(mem_rdata), .idex_rs1(idex_rs1), .idex_rs2(idex_rs2),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .forward_a(forward_a),
    .forward_b(forward_b), .em_result(em_result), .wb_result(wb_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .stall(stall),
    .stall_count(stall_count)
  );

  ex_forward_hazard_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_result(ex_result),
    .mem_rdata(mem_rdata), .idex_rs1(idex_rs1), .idex_rs2(idex_rs2),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .forward_a(fa4),
    .forward_b(fb4), .em_result(em4), .wb_result(wb4),
    .wb_rd(wbrd4), .wb_reg_write(wbwe4), .stall(stall4),
    .stall_count(stall_count4)
  );

  typedef struct {
    logic [1:0]  fa, fb;
    logic [63:0] em, wb;
    logic [4:0]  wbrd;
    logic        wbwe, stall;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  // In-flight producers, youngest first: [0] left EX one cycle ago, [1] two cycles ago.
  typedef struct {
    logic [4:0]  rd;
    bit          we;
    bit          ld;
    logic [63:0] val;
  } prod_t;

  typedef struct {
    bit          v;
    logic [4:0]  rs1, rs2, rd;
    bit          we, ld;
    logic [63:0] res;
  } inst_t;

  exp_t        sb[$];
  prod_t       prod[2];
  bit          model_valid = 0;
  int unsigned m_cnt, m_cnt4;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (prod[i].we && prod[i].rd == rs) begin
        if (i == 0 && prod[i].ld) continue;
        return (i == 0) ? 2'b10 : 2'b01;
      end
    end
    return 2'b00;
  endfunction

  function automatic bit exp_stall();
    return ex_valid && ex_mem_read && ex_rd != 5'd0 &&
           (ex_rd == ifid_rs1 || ex_rd == ifid_rs2);
  endfunction

  task automatic tick();
    bit   s;
    exp_t e;
    s = exp_stall();
    if (model_valid) begin
      e.fa    = exp_fwd(idex_rs1);
      e.fb    = exp_fwd(idex_rs2);
      e.em    = prod[0].val;
      e.wb    = prod[1].val;
      e.wbrd  = prod[1].rd;
      e.wbwe  = prod[1].we;
      e.stall = s;
      e.cnt   = m_cnt;
      e.cnt4  = m_cnt4[3:0];
      sb.push_back(e);
    end
    @(posedge clk);
    if (!reset_n) begin
      prod[0] = '{default: 0};
      prod[1] = '{default: 0};
      m_cnt = 0;
      m_cnt4 = 0;
      model_valid = 1;
    end else begin
      prod[1].rd  = prod[0].rd;
      prod[1].we  = prod[0].we;
      prod[1].ld  = 0;
      prod[1].val = prod[0].ld ? mem_rdata : prod[0].val;
      prod[0].rd  = ex_rd;
      prod[0].we  = ex_valid && ex_reg_write;
      prod[0].ld  = ex_valid && ex_mem_read;
      prod[0].val = ex_result;
      if (s) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
    end
    #1;
  endtask

  task automatic issue(input bit v, input logic [4:0] rd, input bit we, input bit ld,
                       input logic [63:0] res, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] f1, input logic [4:0] f2, input logic [63:0] mrd);
    ex_valid = v; ex_rd = rd; ex_reg_write = we; ex_mem_read = ld; ex_result = res;
    idex_rs1 = r1; idex_rs2 = r2; ifid_rs1 = f1; ifid_rs2 = f2; mem_rdata = mrd;
    tick();
  endtask

  function automatic inst_t new_inst(input bit bubble);
    inst_t n;
    n.v   = bubble ? 1'b0 : ($urandom_range(0, 9) != 0);
    n.rs1 = 5'($urandom_range(0, 7));
    n.rs2 = 5'($urandom_range(0, 7));
    n.rd  = 5'($urandom_range(0, 7));
    n.we  = ($urandom_range(0, 3) != 0);
    n.ld  = n.we && ($urandom_range(0, 2) == 0);
    n.res = {$urandom, $urandom};
    return n;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("forward_a", 64'(forward_a), 64'(e.fa));
        chk("forward_b", 64'(forward_b), 64'(e.fb));
        chk("em_result", em_result, e.em);
        chk("wb_result", wb_result, e.wb);
        chk("wb_rd", 64'(wb_rd), 64'(e.wbrd));
        chk("wb_reg_write", 64'(wb_reg_write), 64'(e.wbwe));
        chk("stall", 64'(stall), 64'(e.stall));
        chk("stall_count", 64'(stall_count), 64'(e.cnt));
        chk("stall_count_w4", 64'(stall_count4), 64'(e.cnt4));
      end
    end
  end

  initial begin : stimulus
    inst_t idr, exr;
    bit    s;

    reset_n = 1'b0;
    issue(1, 5, 1, 0, 64'hAAAA, 0, 0, 0, 0, 0);
    issue(1, 5, 1, 0, 64'hAAAA, 0, 0, 0, 0, 0);
    reset_n = 1'b1;

    // Producer x3, consumer on both operands.
    issue(1, 3, 1, 0, 64'h10, 0, 0, 0, 0, 0);
    issue(1, 0, 0, 0, 64'h0, 3, 3, 0, 0, 0);
    // Two writers of x4: youngest must win.
    issue(1, 4, 1, 0, 64'h1, 0, 0, 0, 0, 0);
    issue(1, 4, 1, 0, 64'h2, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 0, 64'h0, 0, 4, 0, 0, 0);
    // x7 two cycles ahead of its consumer.
    issue(1, 7, 1, 0, 64'h77, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 0, 64'h0, 0, 0, 0, 0, 0);
    issue(1, 0, 0, 0, 64'h0, 7, 0, 0, 0, 0);
    // Writes to x0 never forward.
    issue(1, 0, 1, 0, 64'h55, 0, 0, 0, 0, 0);
    issue(1, 0, 0, 0, 64'h0, 0, 0, 0, 0, 0);
    issue(1, 0, 0, 0, 64'h0, 0, 0, 0, 0, 0);
    // Load-use on x9, bubble, then consumer picks up load data.
    issue(1, 9, 1, 1, 64'h0, 0, 0, 0, 9, 0);
    issue(0, 0, 0, 0, 64'h0, 0, 0, 0, 9, 64'hDEADBEEF);
    issue(1, 0, 0, 0, 64'h0, 0, 9, 0, 0, 0);
    // Load rd matching both ID sources is one stall.
    issue(1, 6, 1, 1, 64'h0, 0, 0, 6, 6, 0);
    issue(0, 0, 0, 0, 64'h0, 0, 0, 0, 0, 64'h1234);
    // Back-to-back stalls drive the narrow counter into saturation.
    for (int i = 0; i < 18; i++) issue(1, 9, 1, 1, 64'(i), 0, 0, 0, 9, 0);
    reset_n = 1'b0;
    issue(1, 9, 1, 1, 64'h0, 0, 0, 0, 9, 0);
    reset_n = 1'b1;
    issue(0, 0, 0, 0, 64'h0, 0, 0, 0, 0, 0);

    // Random instruction stream honouring the stall/bubble protocol.
    idr = new_inst(0);
    exr = new_inst(1);
    for (int c = 0; c < 400; c++) begin
      ex_valid = exr.v; ex_rd = exr.rd; ex_reg_write = exr.we; ex_mem_read = exr.ld;
      ex_result = exr.res; idex_rs1 = exr.rs1; idex_rs2 = exr.rs2;
      ifid_rs1 = idr.rs1; ifid_rs2 = idr.rs2;
      mem_rdata = {$urandom, $urandom};
      s = exp_stall();
      reset_n = !(s && $urandom_range(0, 7) == 0);
      tick();
      if (s) begin
        exr = new_inst(1);
      end else begin
        exr = idr;
        idr = new_inst(0);
      end
    end
    reset_n = 1'b1;

    for (int w = 0; w < 5 && sb.size() > 0; w++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
